// File: rtl/relay_pkg.sv
// Shared types and elaboration helpers for the almost-full FIFO write relay.
package relay_pkg;

    localparam int LEVEL_MAX = 8;

    typedef enum logic {
        IDLE,
        THROTTLED
    } relay_state_t;

    // The downstream FIFO must absorb the producer's own grace plus a full round trip
    // through the relay: LEVEL cycles for full_n back and LEVEL cycles of beats still in flight.
    function automatic bit grace_ok(input int up, input int down, input int level);
        return down >= up + 2 * level;
    endfunction

endpackage

// File: rtl/relay_delay_line.sv
// LEVEL-stage valid/data register chain; valid bits and data reset to zero.
module relay_delay_line
    import relay_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int LEVEL = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             dst_valid,
    output logic [WIDTH-1:0] dst_data
);

    logic [LEVEL-1:0] valid;
    logic [WIDTH-1:0] data [LEVEL];

    // Data only advances behind a valid beat, so idle cycles leave the last payload in place.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
            for (int k = 0; k < LEVEL; k++) begin
                data[k] <= '0;
            end
        end else begin
            valid[0] <= src_valid;
            if (src_valid) begin
                data[0] <= src_data;
            end
            for (int k = 1; k < LEVEL; k++) begin
                valid[k] <= valid[k-1];
                if (valid[k-1]) begin
                    data[k] <= data[k-1];
                end
            end
        end
    end

    assign dst_valid = valid[LEVEL-1];
    assign dst_data  = data[LEVEL-1];

endmodule

// File: rtl/fifo_relay_almost_full.sv
// Pipelined write-side relay for an almost-full FWFT FIFO, with a grace-budget overflow monitor.
module fifo_relay_almost_full
    import relay_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEVEL      = 2,
    parameter int DOWN_GRACE = 6,
    parameter int UP_GRACE   = 2,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  if_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  out_write,
    output logic [DATA_WIDTH-1:0] out_din,
    input  logic                  in_full_n,
    output logic                  overflow,
    output logic [CNT_WIDTH-1:0]  grace_cnt
);

    if (LEVEL < 1 || LEVEL > LEVEL_MAX) begin : g_bad_level
        $error("fifo_relay_almost_full: LEVEL must be in 1..%0d", LEVEL_MAX);
    end
    if (!grace_ok(UP_GRACE, DOWN_GRACE, LEVEL)) begin : g_bad_grace
        $error("fifo_relay_almost_full: DOWN_GRACE must be >= UP_GRACE + 2*LEVEL");
    end
    if (DOWN_GRACE + 1 > 2 ** CNT_WIDTH - 1) begin : g_bad_cnt
        $error("fifo_relay_almost_full: CNT_WIDTH too small to hold DOWN_GRACE+1");
    end

    localparam logic [CNT_WIDTH-1:0] DOWN_GRACE_C = CNT_WIDTH'(DOWN_GRACE);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX      = {CNT_WIDTH{1'b1}};

    logic fn_valid;
    logic fn_data;

    relay_delay_line #(
        .WIDTH (DATA_WIDTH),
        .LEVEL (LEVEL)
    ) u_fwd (
        .clk       (clk),
        .reset     (reset),
        .src_valid (if_write & if_write_ce),
        .src_data  (if_din),
        .dst_valid (out_write),
        .dst_data  (out_din)
    );

    relay_delay_line #(
        .WIDTH (1),
        .LEVEL (LEVEL)
    ) u_full_n (
        .clk       (clk),
        .reset     (reset),
        .src_valid (in_full_n),
        .src_data  (in_full_n),
        .dst_valid (fn_valid),
        .dst_data  (fn_data)
    );

    // The data copy only ever latches a 1 behind a valid 1, so the AND equals the valid chain.
    assign if_full_n = fn_valid & fn_data;

    relay_state_t          state;
    relay_state_t          state_nxt;
    logic [CNT_WIDTH-1:0]  cnt_nxt;
    logic                  overflow_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grace_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nxt;
            grace_cnt <= cnt_nxt;
            overflow  <= overflow_nxt;
        end
    end

    // A write arriving on the same cycle full_n returns high is not charged to the episode.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = grace_cnt;
        overflow_nxt = overflow;
        case (state)
            IDLE: begin
                if (!in_full_n) begin
                    state_nxt = THROTTLED;
                    cnt_nxt   = '0;
                end
            end
            THROTTLED: begin
                if (in_full_n) begin
                    state_nxt = IDLE;
                end else if (out_write) begin
                    if (grace_cnt >= DOWN_GRACE_C) begin
                        overflow_nxt = 1'b1;
                    end
                    if (grace_cnt != CNT_MAX) begin
                        cnt_nxt = grace_cnt + 1'b1;
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_relay_almost_full.sv
// Bench for fifo_relay_almost_full: directed scenarios plus random traffic against a history-based model.
module tb_fifo_relay_almost_full;

    localparam int L    = 2;
    localparam int DW   = 32;
    localparam int DG   = 6;
    localparam int UG   = 2;
    localparam int CW   = 4;
    localparam int HMAX = 4096;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_write_ce = 1'b0;
    logic          if_write = 1'b0;
    logic [DW-1:0] if_din = '0;
    logic          in_full_n = 1'b1;
    logic          if_full_n;
    logic          out_write;
    logic [DW-1:0] out_din;
    logic          overflow;
    logic [CW-1:0] grace_cnt;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    logic          acc_log [HMAX];
    logic [DW-1:0] din_log [HMAX];
    logic          fn_log  [HMAX];

    int epoch = 0;
    bit in_rst = 1'b1;
    bit m_thr = 1'b0;
    bit m_ovf = 1'b0;
    int m_cnt = 0;

    fifo_relay_almost_full #(
        .DATA_WIDTH (DW),
        .LEVEL      (L),
        .DOWN_GRACE (DG),
        .UP_GRACE   (UG),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .if_full_n   (if_full_n),
        .if_write_ce (if_write_ce),
        .if_write    (if_write),
        .if_din      (if_din),
        .out_write   (out_write),
        .out_din     (out_din),
        .in_full_n   (in_full_n),
        .overflow    (overflow),
        .grace_cnt   (grace_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic rst, input logic w, input logic ce,
                                  input logic [DW-1:0] d, input logic fn);
        @(posedge clk);
        #1;
        reset       = rst;
        if_write    = w;
        if_write_ce = ce;
        if_din      = d;
        in_full_n   = fn;
        if (cyc < HMAX) begin
            acc_log[cyc] = w & ce;
            din_log[cyc] = d;
            fn_log[cyc]  = fn;
        end
    endtask

    // Model: outputs are the inputs seen exactly L cycles earlier (never earlier than the
    // last reset release); the monitor is tracked as an episode flag plus a counter.
    always @(negedge clk) begin
        int n;
        logic e_ow;
        logic e_fn;
        logic [DW-1:0] e_din;
        if (reset) begin
            in_rst = 1'b1;
            m_thr  = 1'b0;
            m_cnt  = 0;
            m_ovf  = 1'b0;
            check_output("rst_out_write", {31'b0, out_write}, 32'd0);
            check_output("rst_out_din", out_din, 32'd0);
            check_output("rst_if_full_n", {31'b0, if_full_n}, 32'd0);
            check_output("rst_overflow", {31'b0, overflow}, 32'd0);
            check_output("rst_grace_cnt", {28'b0, grace_cnt}, 32'd0);
        end else begin
            if (in_rst) begin
                epoch  = cyc;
                in_rst = 1'b0;
            end
            n     = cyc;
            e_ow  = 1'b0;
            e_fn  = 1'b0;
            e_din = '0;
            if (n - L >= epoch) begin
                e_ow = acc_log[n-L];
                e_fn = fn_log[n-L];
            end
            for (int m = n - L; m >= epoch; m--) begin
                if (acc_log[m]) begin
                    e_din = din_log[m];
                    break;
                end
            end
            check_output("out_write", {31'b0, out_write}, {31'b0, e_ow});
            check_output("out_din", out_din, e_din);
            check_output("if_full_n", {31'b0, if_full_n}, {31'b0, e_fn});
            check_output("overflow", {31'b0, overflow}, {31'b0, m_ovf});
            check_output("grace_cnt", {28'b0, grace_cnt}, 32'(m_cnt));
            if (!m_thr) begin
                if (!fn_log[n]) begin
                    m_thr = 1'b1;
                    m_cnt = 0;
                end
            end else if (fn_log[n]) begin
                m_thr = 1'b0;
            end else if (e_ow) begin
                if (m_cnt >= DG) m_ovf = 1'b1;
                if (m_cnt < 2 ** CW - 1) m_cnt++;
            end
        end
    end

    initial begin
        logic fn_state;
        logic w;
        logic ce;

        repeat (3) apply_stimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);

        $display("[TB] reset release, full_n propagation");
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
            @(negedge clk);
            check_output("lit_if_full_n_release", {31'b0, if_full_n}, (i >= 2) ? 32'd1 : 32'd0);
            check_output("lit_idle_out_write", {31'b0, out_write}, 32'd0);
        end

        $display("[TB] burst A0..A7");
        for (int i = 0; i < 12; i++) begin
            if (i < 8) apply_stimulus(1'b0, 1'b1, 1'b1, 32'hA0 + 32'(i), 1'b1);
            else       apply_stimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
            @(negedge clk);
            if (i >= 2 && i < 10) begin
                check_output("lit_burst_write", {31'b0, out_write}, 32'd1);
                check_output("lit_burst_din", out_din, 32'hA0 + 32'(i - 2));
            end else begin
                check_output("lit_burst_gap", {31'b0, out_write}, 32'd0);
            end
        end

        $display("[TB] write without clock enable");
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b0, (i < 3), 1'b0, 32'h55, 1'b1);
            @(negedge clk);
            check_output("lit_ce_low", {31'b0, out_write}, 32'd0);
        end

        $display("[TB] grace respected");
        for (int j = -3; j <= 12; j++) begin
            apply_stimulus(1'b0, (j <= 4), 1'b1, 32'hC0 + 32'(j + 3), !(j >= 0 && j <= 8));
            @(negedge clk);
            if (j == 8) begin
                check_output("lit_grace_cnt6", {28'b0, grace_cnt}, 32'd6);
                check_output("lit_no_overflow", {31'b0, overflow}, 32'd0);
            end
            if (j == 12) check_output("lit_grace_hold", {28'b0, grace_cnt}, 32'd6);
        end

        $display("[TB] grace exceeded");
        for (int j = -3; j <= 14; j++) begin
            apply_stimulus(1'b0, (j <= 6), 1'b1, 32'hD0 + 32'(j + 3), !(j >= 0 && j <= 9));
            @(negedge clk);
            if (j == 7)  check_output("lit_ovf_before", {31'b0, overflow}, 32'd0);
            if (j == 8)  check_output("lit_ovf_set", {31'b0, overflow}, 32'd1);
            if (j == 9)  check_output("lit_grace_cnt8", {28'b0, grace_cnt}, 32'd8);
            if (j == 14) check_output("lit_ovf_sticky", {31'b0, overflow}, 32'd1);
        end

        $display("[TB] async reset mid-burst");
        for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b1, 1'b1, 32'hB0 + 32'(i), 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_output("lit_async_out_write", {31'b0, out_write}, 32'd0);
        check_output("lit_async_if_full_n", {31'b0, if_full_n}, 32'd0);
        check_output("lit_async_overflow", {31'b0, overflow}, 32'd0);
        repeat (2) apply_stimulus(1'b1, 1'b1, 1'b1, 32'hBB, 1'b1);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
            @(negedge clk);
            check_output("lit_no_stale", {31'b0, out_write}, 32'd0);
        end

        $display("[TB] random traffic");
        fn_state = 1'b1;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 9) == 0) fn_state = ~fn_state;
            w  = if_full_n ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 1);
            ce = ($urandom_range(0, 9) < 9);
            apply_stimulus((k == 300 || k == 301), w, ce, $urandom, fn_state);
        end
        repeat (3) apply_stimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
